// File: rtl/morse_display_ctrl.sv
// morse_display_ctrl: character buffer for a multi-digit seven-segment display.
// Characters arrive either as indexed writes or as shift-in appends. The
// buffer is decoded to active-low glyphs onto a static per-digit segment
// bus, and a refresh counter time-multiplexes one digit at a time onto
// the scanned anode/cathode pins.
//
// Ports:
//   clk_100Mhz  - sole clock, rising edge
//   reset       - asynchronous, active-high
//   data_valid  - char_data/char_index qualified this cycle
//   char_index  - target digit for indexed writes (0 = rightmost)
//   char_data   - 6-bit character code
//   scroll_mode - 0 = indexed write, 1 = shift-in append at digit 0
//   clear       - synchronous blank of all digits, wins over data_valid
//   seg         - static glyph bus, digit i at seg[7i+6:7i], active-low
//   an          - scanned anode enables, active-low, one-hot-low
//   cath        - cathodes of the currently enabled digit, active-low
module morse_display_ctrl #(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic                                clk_100Mhz,
   input  logic                                reset,
   input  logic                                data_valid,
   input  logic [$clog2(NUM_DIGITS)-1:0]       char_index,
   input  logic [5:0]                          char_data,
   input  logic                                scroll_mode,
   input  logic                                clear,
   output logic [7*NUM_DIGITS-1:0]             seg,
   output logic [NUM_DIGITS-1:0]               an,
   output logic [6:0]                          cath
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned SEG_W = 7 * NUM_DIGITS;

   logic [NUM_DIGITS-1:0][5:0] buf_q, buf_d;
   logic [SEG_W-1:0]           seg_q, seg_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [IDX_W-1:0]           ptr_q, ptr_d;
   logic [NUM_DIGITS-1:0]      an_q, an_d;
   logic [6:0]                 cath_q, cath_d;

   // Character code to active-low glyph, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph(input logic [5:0] code);
      logic [6:0] g;
      g = 7'b1111111;
      case (code)
         6'd1:  g = 7'b0001000; // A
         6'd2:  g = 7'b0000011; // b
         6'd3:  g = 7'b1000110; // C
         6'd4:  g = 7'b0100001; // d
         6'd5:  g = 7'b0000110; // E
         6'd6:  g = 7'b0001110; // F
         6'd7:  g = 7'b1000010; // G
         6'd8:  g = 7'b0001001; // H
         6'd9:  g = 7'b1111001; // I
         6'd10: g = 7'b1100001; // J
         6'd11: g = 7'b0001010; // K
         6'd12: g = 7'b1000111; // L
         6'd13: g = 7'b1001000; // M
         6'd14: g = 7'b0101011; // n
         6'd15: g = 7'b1000000; // O
         6'd16: g = 7'b0001100; // P
         6'd17: g = 7'b0011000; // q
         6'd18: g = 7'b0101111; // r
         6'd19: g = 7'b0010010; // S
         6'd20: g = 7'b0000111; // t
         6'd21: g = 7'b1000001; // U
         6'd22: g = 7'b1100011; // v
         6'd23: g = 7'b1010101; // W
         6'd24: g = 7'b0001001; // X
         6'd25: g = 7'b0010001; // y
         6'd26: g = 7'b0100100; // Z
         6'd27: g = 7'b1000000; // 0
         6'd28: g = 7'b1111001; // 1
         6'd29: g = 7'b0100100; // 2
         6'd30: g = 7'b0110000; // 3
         6'd31: g = 7'b0011001; // 4
         6'd32: g = 7'b0010010; // 5
         6'd33: g = 7'b0000010; // 6
         6'd34: g = 7'b1111000; // 7
         6'd35: g = 7'b0000000; // 8
         6'd36: g = 7'b0010000; // 9
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   // Buffer update: clear, then shift-in append, then indexed write.
   always_comb begin
      buf_d = buf_q;
      if (clear) begin
         buf_d = '0;
      end else if (data_valid) begin
         if (scroll_mode) begin
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
               buf_d[i] = buf_q[i-1];
            end
            buf_d[0] = char_data;
         end else begin
            // Indices past the last digit exist only for non-power-of-2 sizes.
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (char_index == IDX_W'(i)) begin
                  buf_d[i] = char_data;
               end
            end
         end
      end
   end

   // Static glyph bus decoded from the current buffer.
   always_comb begin
      seg_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         seg_d[7*i +: 7] = glyph(buf_q[i]);
      end
   end

   // Refresh counter and digit pointer; independent of all write controls.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      ptr_d = ptr_q;
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_d = '0;
         if (ptr_q == IDX_W'(NUM_DIGITS - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_q + IDX_W'(1);
         end
      end
   end

   // Scan outputs for the digit the pointer selects.
   always_comb begin
      an_d   = '1;
      cath_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ptr_q == IDX_W'(i)) begin
            an_d[i] = 1'b0;
            cath_d  = seg_q[7*i +: 7];
         end
      end
   end

   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         buf_q  <= '0;
         seg_q  <= '1;
         cnt_q  <= '0;
         ptr_q  <= '0;
         an_q   <= '1;
         cath_q <= '1;
      end else begin
         buf_q  <= buf_d;
         seg_q  <= seg_d;
         cnt_q  <= cnt_d;
         ptr_q  <= ptr_d;
         an_q   <= an_d;
         cath_q <= cath_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign cath = cath_q;

endmodule

// File: tb/tb_morse_display_ctrl.sv
// tb_morse_display_ctrl: directed bench for morse_display_ctrl with an
// 8-digit instance and a 6-digit instance, both refreshing every 4 cycles.
module tb_morse_display_ctrl;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GB = 7'b0000011;
   localparam logic [6:0] GC = 7'b1000110;
   localparam logic [6:0] GD = 7'b0100001;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] GF = 7'b0001110;
   localparam logic [6:0] GG = 7'b1000010;
   localparam logic [6:0] GH = 7'b0001001;
   localparam logic [6:0] GI = 7'b1111001;
   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D9 = 7'b0010000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        dv8 = 1'b0, scroll8 = 1'b0, clear8 = 1'b0;
   logic [2:0]  idx8 = '0;
   logic [5:0]  data8 = '0;
   logic [55:0] seg8;
   logic [7:0]  an8;
   logic [6:0]  cath8;

   logic        dv6 = 1'b0, scroll6 = 1'b0, clear6 = 1'b0;
   logic [2:0]  idx6 = '0;
   logic [5:0]  data6 = '0;
   logic [41:0] seg6;
   logic [5:0]  an6;
   logic [6:0]  cath6;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   morse_display_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut8 (
      .clk_100Mhz (clk),   .reset      (rst),
      .data_valid (dv8),   .char_index (idx8),
      .char_data  (data8), .scroll_mode(scroll8),
      .clear      (clear8),
      .seg        (seg8),  .an         (an8),   .cath (cath8)
   );

   morse_display_ctrl #(.NUM_DIGITS(6), .REFRESH_DIV(4)) dut6 (
      .clk_100Mhz (clk),   .reset      (rst),
      .data_valid (dv6),   .char_index (idx6),
      .char_data  (data6), .scroll_mode(scroll6),
      .clear      (clear6),
      .seg        (seg6),  .an         (an6),   .cath (cath6)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for a given anode pattern, then compare cathodes.
   task automatic scan_probe(input string tag, input logic [7:0] target, input logic [6:0] exp_cath);
      for (int i = 0; i < 40; i++) begin
         if (an8 == target) break;
         tick();
      end
      check({tag, "_an"}, 64'(an8), 64'(target));
      check({tag, "_cath"}, 64'(cath8), 64'(exp_cath));
   endtask

   initial begin
      // Reset state
      tick();
      check("rst_seg8", 64'(seg8), 64'({8{BL}}));
      check("rst_an8", 64'(an8), 64'hff);
      check("rst_cath8", 64'(cath8), 64'(BL));
      check("rst_an6", 64'(an6), 64'h3f);
      rst = 1'b0;

      // Scan from release: edge k shows digit ((k-1)/4) mod N
      tick();
      check("scan_k1_an", 64'(an8), 64'hfe);
      check("scan_k1_cath", 64'(cath8), 64'(BL));
      check("scan6_k1_an", 64'(an6), 64'h3e);
      for (int k = 2; k <= 33; k++) begin
         tick();
         case (k)
            4:  check("scan_k4_an",  64'(an8), 64'hfe);
            5:  check("scan_k5_an",  64'(an8), 64'hfd);
            8:  check("scan_k8_an",  64'(an8), 64'hfd);
            9:  check("scan_k9_an",  64'(an8), 64'hfb);
            13: check("scan_k13_an", 64'(an8), 64'hf7);
            21: check("scan6_k21_an", 64'(an6), 64'h1f);
            25: check("scan6_k25_an", 64'(an6), 64'h3e);
            29: check("scan_k29_an", 64'(an8), 64'h7f);
            33: check("scan_k33_an", 64'(an8), 64'hfe);
            default: ;
         endcase
      end

      // 6-digit instance: valid write, then out-of-range writes ignored
      dv6 = 1'b1; idx6 = 3'd2; data6 = 6'd1;
      tick();
      dv6 = 1'b0;
      tick();
      check("oor_base_seg6", 64'(seg6), 64'({{3{BL}}, GA, {2{BL}}}));
      dv6 = 1'b1; idx6 = 3'd7; data6 = 6'd5;
      tick();
      idx6 = 3'd6;
      tick();
      dv6 = 1'b0;
      tick();
      tick();
      check("oor_seg6", 64'(seg6), 64'({{3{BL}}, GA, {2{BL}}}));

      // Indexed write: code 1 at digit 3, visible two edges later
      dv8 = 1'b1; scroll8 = 1'b0; idx8 = 3'd3; data8 = 6'd1;
      tick();
      dv8 = 1'b0;
      check("idx_latency_seg8", 64'(seg8), 64'({8{BL}}));
      tick();
      check("idx_seg8", 64'(seg8), 64'({{4{BL}}, GA, {3{BL}}}));

      // Clear wins over a same-edge write
      clear8 = 1'b1; dv8 = 1'b1; idx8 = 3'd0; data8 = 6'd5;
      tick();
      clear8 = 1'b0; dv8 = 1'b0;
      tick();
      check("clear_prio_seg8", 64'(seg8), 64'({8{BL}}));

      // Back-to-back indexed writes, including digit and blank codes
      dv8 = 1'b1;
      idx8 = 3'd0; data8 = 6'd27; tick();
      idx8 = 3'd1; data8 = 6'd28; tick();
      idx8 = 3'd2; data8 = 6'd29; tick();
      idx8 = 3'd7; data8 = 6'd36; tick();
      idx8 = 3'd6; data8 = 6'd40; tick();
      dv8 = 1'b0;
      tick();
      check("b2b_seg8", 64'(seg8), 64'({D9, {4{BL}}, D2, D1, D0}));

      // Scroll append of codes 1..9: code 1 falls off the top
      dv8 = 1'b1; scroll8 = 1'b1; idx8 = 3'd5;
      for (int c = 1; c <= 9; c++) begin
         data8 = 6'(c);
         tick();
      end
      dv8 = 1'b0; scroll8 = 1'b0;
      tick();
      check("scroll_seg8", 64'(seg8), 64'({GB, GC, GD, GE, GF, GG, GH, GI}));
      check("scroll_top_digit", 64'(seg8[55:49]), 64'(GB));

      // Cathodes follow the enabled digit's glyph
      scan_probe("scan_d3", 8'hf7, GF);
      scan_probe("scan_d0", 8'hfe, GI);
      scan_probe("scan_d7", 8'h7f, GB);

      // Asynchronous reset between edges during a write
      dv8 = 1'b1; idx8 = 3'd4; data8 = 6'd1;
      #2;
      rst = 1'b1;
      #1;
      check("async_seg8", 64'(seg8), 64'({8{BL}}));
      check("async_an8", 64'(an8), 64'hff);
      check("async_cath8", 64'(cath8), 64'(BL));
      tick();
      tick();
      dv8 = 1'b0;
      rst = 1'b0;
      tick();
      check("post_rst_an8", 64'(an8), 64'hfe);
      check("post_rst_cath8", 64'(cath8), 64'(BL));
      tick();
      check("post_rst_seg8", 64'(seg8), 64'({8{BL}}));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/morse_display_ctrl.md
MORSE_DISPLAY_CTRL -- requirements
Module: morse_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of seven-segment digits held and driven (legal 2..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clock cycles each digit is enabled during scan (legal >= 2).
REQ-003 SHALL have derived localparam IDX_W = clog2(NUM_DIGITS): width of char_index.
REQ-004 SHALL have port clk_100Mhz  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_valid  input  1  char_data/char_index qualified this cycle.
REQ-007 SHALL have port char_index  input  IDX_W  target digit for indexed writes (0 = rightmost).
REQ-008 SHALL have port char_data  input  6  character code.
REQ-009 SHALL have port scroll_mode  input  1  0 = indexed write, 1 = shift-in append.
REQ-010 SHALL have port clear  input  1  synchronous blank of all digits.
REQ-011 SHALL have port seg  output  7*NUM_DIGITS  static glyph bus; digit i at seg[7i+6:7i].
REQ-012 SHALL have port an  output  NUM_DIGITS  scanned anode enables, active-low.
REQ-013 SHALL have port cath  output  7  scanned cathodes for the enabled digit, active-low.

Function
REQ-014 SHALL hold a character buffer of NUM_DIGITS 6-bit codes; reset value 0 (blank) in every entry.
REQ-015 SHALL map codes to active-low glyphs, bit order {g,f,e,d,c,b,a}: 0 = blank 7'b1111111; 1..26 = A..Z per team letter table (A = 7'b0001000, E = 7'b0000110); 27..36 = digits 0..9 ('0' = 7'b1000000, '1' = 7'b1111001); 37..63 = blank.
REQ-016 SHALL, with data_valid=1 and scroll_mode=0, write char_data into buffer[char_index] at the sampling edge; other entries unchanged.
REQ-017 SHALL ignore indexed writes with char_index >= NUM_DIGITS (non-power-of-2 NUM_DIGITS); buffer unchanged.
REQ-018 SHALL, with data_valid=1 and scroll_mode=1, shift buffer[i] <= buffer[i-1] for i>=1 and buffer[0] <= char_data; buffer[NUM_DIGITS-1] discarded; char_index ignored.
REQ-019 SHALL give clear priority over data_valid: clear=1 blanks all entries that edge regardless of data_valid.
REQ-020 SHALL register seg from the decoded buffer: buffer update at edge N appears on seg at edge N+1 (2-edge latency from data_valid sample).
REQ-021 SHALL run a refresh counter 0..REFRESH_DIV-1; on wrap, digit pointer advances ptr <= (ptr+1) mod NUM_DIGITS (wrap NUM_DIGITS-1 -> 0).
REQ-022 SHALL register an = ~(1 << ptr) and cath = seg[7*ptr+6:7*ptr] each cycle; exactly one an bit low outside reset.
REQ-023 SHALL keep scan timing independent of writes/clear: counter and ptr are unaffected by data_valid, clear, scroll_mode.
REQ-024 SHALL accept back-to-back writes every cycle with no stall; no write is dropped.

Reset
REQ-025 SHALL, on reset assertion, immediately (asynchronously) set buffer to 0, seg to all ones, counter 0, ptr 0, an all ones, cath all ones.
REQ-026 SHALL, on first edge after reset release, drive an = ~1 (digit 0) with cath = 7'b1111111.
REQ-027 SHALL, on reset mid-scan or mid-write, discard the in-flight write; no partial update survives.

Verification
REQ-028 SHALL verify indexed write: NUM_DIGITS=8, write code 1 to index 3 -> two edges later seg[27:21]=7'b0001000, all other digits 7'b1111111.
REQ-029 SHALL verify scroll: scroll_mode=1, append codes 1,2,...,9 on consecutive cycles -> buffer[0]=9, buffer[7]=2, code 1 lost; seg[55:49]=glyph(2).
REQ-030 SHALL verify clear priority: clear=1 and data_valid=1 (code 5, index 0) same edge -> all seg digits 7'b1111111 next-next edge.
REQ-031 SHALL verify scan: REFRESH_DIV=4, NUM_DIGITS=8 -> an steps 11111110,11111101,... every 4 cycles, returns to 11111110 after 32 cycles; cath equals enabled digit's seg slice.
REQ-032 SHALL verify out-of-range index: NUM_DIGITS=6, write to char_index 7 -> buffer and seg unchanged.
REQ-033 SHALL verify async reset mid-operation: assert reset between edges during writes -> seg, an, cath go to all ones without a clock edge; after release digit 0 enabled, blank.
